// File: rtl/grid_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | grid_pkg : shared types for the 8x8 grid-world Q-learning path   |
// | Rev 1.0  : initial release                                       |
// +-----------------------------------------------------------------+
package grid_pkg;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  localparam int ACT_W = 2;
  localparam int RWD_W = 8;
  localparam int ST_W  = ROW_W + COL_W;

  localparam logic [ACT_W-1:0] ACT_LEFT  = 2'b00;
  localparam logic [ACT_W-1:0] ACT_UP    = 2'b01;
  localparam logic [ACT_W-1:0] ACT_RIGHT = 2'b10;
  localparam logic [ACT_W-1:0] ACT_DOWN  = 2'b11;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } state_t;

  typedef struct packed {
    logic [ST_W-1:0]  s;
    logic [ACT_W-1:0] a;
    logic [RWD_W-1:0] r;
    logic [ST_W-1:0]  ns;
    logic             done;
  } tr_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_OUT  = 2'd3
  } fsm_t;
endpackage
`default_nettype wire

// File: rtl/grid_move.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | grid_move : (state, action) -> next state with wall clamping     |
// | Rev 1.0   : initial release                                      |
// +-----------------------------------------------------------------+
module grid_move
  import grid_pkg::*;
(
  input  logic [ST_W-1:0]  i_state,
  input  logic [ACT_W-1:0] i_act,
  output logic [ST_W-1:0]  o_next
);
  state_t w_s;
  state_t w_n;

  assign w_s    = i_state;
  assign o_next = w_n;

  // A move into a wall leaves the agent where it is.
  always_comb begin
    w_n = w_s;
    case (i_act)
      ACT_LEFT:  if (w_s.col != '0)              w_n.col = w_s.col - 1'b1;
      ACT_UP:    if (w_s.row != '0)              w_n.row = w_s.row - 1'b1;
      ACT_RIGHT: if (w_s.col != {COL_W{1'b1}})   w_n.col = w_s.col + 1'b1;
      ACT_DOWN:  if (w_s.row != {ROW_W{1'b1}})   w_n.row = w_s.row + 1'b1;
      default:   w_n = w_s;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/grid_env_step.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | grid_env_step : reward fetch, next-state and transition emitter  |
// | Rev 1.0       : initial release                                  |
// +-----------------------------------------------------------------+
module grid_env_step
  import grid_pkg::*;
#(
  parameter logic [ST_W-1:0] START_STATE = 6'b000_000,
  parameter logic [ST_W-1:0] GOAL_STATE  = 6'b111_111,
  parameter int              MAX_STEPS   = 255,
  parameter int              STEP_W      = 8,
  parameter int              EP_W        = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_act_valid,
  output logic                    o_act_ready,
  input  logic [ACT_W-1:0]        i_act,
  output logic [ST_W+ACT_W-1:0]   o_r_addr,
  output logic                    o_r_read,
  input  logic [RWD_W-1:0]        i_r_data,
  output logic                    o_tr_valid,
  input  logic                    i_tr_ready,
  output logic [ST_W-1:0]         o_tr_state,
  output logic [ACT_W-1:0]        o_tr_action,
  output logic [RWD_W-1:0]        o_tr_reward,
  output logic [ST_W-1:0]         o_tr_next_state,
  output logic                    o_tr_done,
  output logic [ST_W-1:0]         o_cur_state,
  output logic [STEP_W-1:0]       o_step_cnt,
  output logic [EP_W-1:0]         o_episode_cnt
);
  fsm_t                   r_fsm;
  logic [ACT_W-1:0]       r_act;
  logic [ST_W+ACT_W-1:0]  r_addr;
  logic                   r_read;
  logic                   r_ready;
  logic                   r_tv;
  tr_t                    r_tr;
  logic [ST_W-1:0]        r_cur;
  logic [STEP_W-1:0]      r_step;
  logic [EP_W-1:0]        r_ep;
  logic [ST_W-1:0]        w_next;
  logic                   w_done;

  grid_move u_move (
    .i_state (r_cur),
    .i_act   (r_act),
    .o_next  (w_next)
  );

  assign w_done = (w_next == GOAL_STATE) || (r_step == STEP_W'(MAX_STEPS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm   <= S_IDLE;
      r_act   <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_ready <= 1'b1;
      r_tv    <= 1'b0;
      r_tr    <= '0;
      r_cur   <= START_STATE;
      r_step  <= '0;
      r_ep    <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: if (i_act_valid) begin
          r_act   <= i_act;
          r_addr  <= {r_cur, i_act};
          r_read  <= 1'b1;
          r_ready <= 1'b0;
          r_fsm   <= S_RD;
        end
        S_RD: begin
          r_read <= 1'b0;
          r_fsm  <= S_CAP;
        end
        // ROM data sampled at the previous edge is now on i_r_data.
        S_CAP: begin
          r_tr.s    <= r_cur;
          r_tr.a    <= r_act;
          r_tr.r    <= i_r_data;
          r_tr.ns   <= w_next;
          r_tr.done <= w_done;
          r_tv      <= 1'b1;
          r_fsm     <= S_OUT;
        end
        S_OUT: if (i_tr_ready) begin
          r_tv    <= 1'b0;
          r_ready <= 1'b1;
          r_fsm   <= S_IDLE;
          if (r_tr.done) begin
            r_cur  <= START_STATE;
            r_step <= '0;
            r_ep   <= r_ep + 1'b1;
          end else begin
            r_cur  <= r_tr.ns;
            r_step <= r_step + 1'b1;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign o_act_ready     = r_ready;
  assign o_r_addr        = r_addr;
  assign o_r_read        = r_read;
  assign o_tr_valid      = r_tv;
  assign o_tr_state      = r_tr.s;
  assign o_tr_action     = r_tr.a;
  assign o_tr_reward     = r_tr.r;
  assign o_tr_next_state = r_tr.ns;
  assign o_tr_done       = r_tr.done;
  assign o_cur_state     = r_cur;
  assign o_step_cnt      = r_step;
  assign o_episode_cnt   = r_ep;
endmodule
`default_nettype wire

// File: doc/grid_env_step.md
Name: grid_env_step

Overview:
- Environment-step stage directly upstream of the reward ROM in the grid-world Q-learning datapath (8x8 grid).
- Accepts an action for the current agent state and forms the reward-ROM address {row, col, action}.
- Captures the registered reward and computes the next state with wall clamping.
- Emits a (s, a, r, s', done) transition to the Q-update stage over a valid/ready handshake. Tracks episode and step counts.

Parameters:
- ROW_W, 3, row index width (8 rows)
- COL_W, 3, column index width (8 columns)
- ACT_W, 2, action width
- RWD_W, 8, reward width (two's complement, passed through uninterpreted)
- START_STATE, 6'b000_000, state loaded at reset and after every done
- GOAL_STATE, 6'b111_111, terminal state
- MAX_STEPS, 255, step limit per episode; done is forced on step MAX_STEPS
- STEP_W, 8, step counter width
- EP_W, 16, episode counter width

Ports:
- i_clk, in, 1, clock
- i_rst, in, 1, synchronous active-high reset
- i_act_valid, in, 1, action offered
- o_act_ready, out, 1, stage can accept an action
- i_act, in, 2, action: 00 left (col-1), 01 up (row-1), 10 right (col+1), 11 down (row+1)
- o_r_addr, out, 8, reward-ROM address {row, col, action}
- o_r_read, out, 1, read strobe to the reward ROM
- i_r_data, in, 8, reward from the ROM, valid one clock after the address is sampled
- o_tr_valid, out, 1, transition valid
- i_tr_ready, in, 1, downstream accepts the transition
- o_tr_state, out, 6, s
- o_tr_action, out, 2, a
- o_tr_reward, out, 8, r
- o_tr_next_state, out, 6, s'
- o_tr_done, out, 1, episode ends with this transition
- o_cur_state, out, 6, current agent state {row, col}
- o_step_cnt, out, STEP_W, steps taken in the current episode
- o_episode_cnt, out, EP_W, completed episodes (wraps)

Behaviour:
- Interface rules
  - One clock, i_clk. Reset i_rst is synchronous and active-high.
  - All outputs are registered.
- Reset values
  - All outputs 0, except o_cur_state = START_STATE and o_act_ready = 1.
  - FSM state S_IDLE.
  - Reset at any point, including mid-transaction, drops o_tr_valid the next cycle and discards any in-flight action.
- FSM states: S_IDLE, S_RD, S_CAP, S_OUT.
- S_IDLE
  - o_act_ready = 1.
  - On i_act_valid at edge N: latch action, register o_r_addr = {cur_state, i_act}, set o_r_read = 1, go to S_RD.
- S_RD
  - o_act_ready = 0. Address is stable; the ROM samples it at edge N+1.
  - o_r_read returns to 0, so it is high for exactly one cycle. Go to S_CAP.
- S_CAP
  - At edge N+2: capture i_r_data into o_tr_reward.
  - Load o_tr_state, o_tr_action, o_tr_next_state and o_tr_done.
  - Set o_tr_valid = 1 and go to S_OUT. Latency from accept to valid is 2 edges.
- S_OUT
  - Hold all o_tr_* stable while i_tr_ready = 0. i_act_valid is ignored.
  - On i_tr_valid & i_tr_ready: clear o_tr_valid, update the counters and state (below), and return to S_IDLE.
  - Earliest next accept is the following edge, giving a throughput of 1 transition per 4 cycles.
- Next-state rules
  - Left at col 0, up at row 0, right at col 7, down at row 7: s' = s.
  - Otherwise move by one cell. Arithmetic never wraps.
- done = (s' == GOAL_STATE) | (o_step_cnt == MAX_STEPS-1).
- On handshake when done = 1:
  - o_cur_state <= START_STATE.
  - o_step_cnt <= 0.
  - o_episode_cnt <= o_episode_cnt + 1, wrapping modulo 2^EP_W.
- On handshake when done = 0:
  - o_cur_state <= s'.
  - o_step_cnt <= o_step_cnt + 1.
- Reward is never decoded. Wall detection is purely geometric. A wall bounce with a nonzero or zero reward behaves the same.
- o_r_addr holds its last value outside S_RD.

Decomposition:
- Package grid_pkg holds:
  - action encodings ACT_LEFT/UP/RIGHT/DOWN
  - ROW_W, COL_W, ACT_W, RWD_W
  - state typedef {row, col}
  - transition struct (s, a, r, s', done)
  - FSM state enum
- Sub-module grid_move: combinational (state, action) -> next state, including wall clamping. It is reused later by the action selector for lookahead.

Test Plan:
- Reset check: assert i_rst for 2 cycles -> o_cur_state = 0, o_act_ready = 1, o_tr_valid = 0, both counters 0.
- Legal move: state (0,0), act 10 -> o_r_addr = 8'b000_000_10 with o_r_read high for 1 cycle; ROM model returns 8'h00 -> tr = {s=0, a=2, r=0, s'=6'b000_001, done=0}, valid exactly 2 edges after accept.
- Wall bounce: state (0,0), act 01 -> o_r_addr = 8'b000_000_01; ROM returns 8'h01 -> o_tr_reward = 8'h01 passed through, s' = 6'b000_000, done = 0, o_step_cnt = 1 after handshake.
- Goal reach: drive to (6,7), act 11 -> o_r_addr = 8'b110_111_11, r = 8'hFF, s' = 6'b111_111, done = 1; after handshake o_cur_state = 0, o_step_cnt = 0, o_episode_cnt = 1.
- Backpressure and step limit:
  - Hold i_tr_ready = 0 for 5 cycles with i_act_valid = 1 -> o_tr_* stable, o_act_ready = 0, no new address issued.
  - With MAX_STEPS = 4, four left moves at (0,0) -> 4th transition has done = 1 and o_episode_cnt increments.
- Mid-op reset: assert i_rst while in S_CAP -> next cycle o_tr_valid = 0, o_act_ready = 1, o_cur_state = START_STATE, no transition emitted.
